// File: rtl/dds_sweep_ctrl.sv
// Linear frequency-sweep sequencer driving the freq/synch inputs of one dds_slave.
// Latency: first point one cycle after start; synch pulses exactly max(dwell_time,1) cycles apart.
// Backpressure: none; start is ignored while busy, and abort returns to idle on the next cycle.
//
// Ports:
//   clk, reset_n         clock and asynchronous active-low reset
//   start, abort         sweep request (ignored while busy) / terminate (wins over start)
//   f_start, f_step      first frequency word and two's-complement per-point increment
//   n_steps, dwell_time  number of points and cycles between consecutive synch pulses
//   ph_adj_ready         dds_slave phase-adjust done flag
//   freq, synch          frequency word and its one-cycle load strobe
//   ph_adj_start         one-cycle phase-adjust trigger
//   busy, done           sweep in progress / one-cycle normal-completion pulse
//   step_idx             0-based index of the current point
//
// Optional feature: define DDS_SWEEP_PHADJ_EN to trigger a phase adjustment after each
// point and hold the dwell until ph_adj_ready. Without it ph_adj_start is tied low and
// ph_adj_ready is ignored.
module dds_sweep_ctrl #(
    parameter int IDX_W   = 16,
    parameter int DWELL_W = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               abort,
    input  logic [31:0]        f_start,
    input  logic [31:0]        f_step,
    input  logic [IDX_W-1:0]   n_steps,
    input  logic [DWELL_W-1:0] dwell_time,
    input  logic               ph_adj_ready,
    output logic [31:0]        freq,
    output logic               synch,
    output logic               ph_adj_start,
    output logic               busy,
    output logic               done,
    output logic [IDX_W-1:0]   step_idx
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_DWELL  = 3'd2,
        S_FINISH = 3'd3
`ifdef DDS_SWEEP_PHADJ_EN
        ,
        S_PHWAIT = 3'd4
`endif
    } state_t;

    state_t state;
    state_t state_nxt;
    state_t adv_state;

    // Sweep parameters captured when a start is accepted
    logic [31:0]        step_r;
    logic [IDX_W-1:0]   n_r;
    logic [DWELL_W-1:0] dwell_r;

    // Cycles remaining before the next point; 0 means advance this cycle
    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] dw_src;
    logic [DWELL_W-1:0] cnt_load;
    logic               cnt_zero;

    logic               accept;
    logic [IDX_W:0]     idx_plus1;
    logic               more_pts;

    logic [31:0]        freq_nxt;
    logic [IDX_W-1:0]   step_idx_nxt;
    logic               synch_nxt;
    logic               busy_nxt;
    logic               done_nxt;

    assign accept   = (state == S_IDLE) && start && !abort;
    assign cnt_zero = (cnt == '0);

    // On the first point the parameters are not yet latched, so use the live input
    assign dw_src   = (state == S_IDLE) ? dwell_time : dwell_r;
    assign cnt_load = (dw_src == '0) ? '0 : dw_src - DWELL_W'(1);

    // step_idx < n_steps-1 written without the subtraction so n_steps=1 cannot underflow
    assign idx_plus1 = {1'b0, step_idx} + (IDX_W + 1)'(1);
    assign more_pts  = idx_plus1 < {1'b0, n_r};
    assign adv_state = more_pts ? S_ISSUE : S_FINISH;

`ifdef DDS_SWEEP_PHADJ_EN
    // Guard so ready is not sampled until two cycles after the ph_adj_start pulse
    logic [1:0] ph_hold;
    logic       ph_ok;
    logic       ph_adj_start_nxt;

    assign ph_ok = ph_adj_ready && (ph_hold == 2'd0);
`else
    logic unused_ph_adj_ready;

    assign unused_ph_adj_ready = ph_adj_ready;
    assign ph_adj_start        = 1'b0;
`endif

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            step_r   <= '0;
            n_r      <= '0;
            dwell_r  <= '0;
            cnt      <= '0;
            freq     <= '0;
            step_idx <= '0;
            synch    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef DDS_SWEEP_PHADJ_EN
            ph_hold      <= 2'd0;
            ph_adj_start <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (accept) begin
                step_r  <= f_step;
                n_r     <= n_steps;
                dwell_r <= dwell_time;
            end
            if (state_nxt == S_ISSUE) begin
                cnt <= cnt_load;
            end else if (state_nxt == S_DWELL) begin
                cnt <= cnt - DWELL_W'(1);
            end
            freq     <= freq_nxt;
            step_idx <= step_idx_nxt;
            synch    <= synch_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
`ifdef DDS_SWEEP_PHADJ_EN
            if (state != S_PHWAIT && state_nxt == S_PHWAIT) begin
                ph_hold <= 2'd2;
            end else if (state == S_PHWAIT && ph_hold != 2'd0) begin
                ph_hold <= ph_hold - 2'd1;
            end
            ph_adj_start <= ph_adj_start_nxt;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    state_nxt = (n_steps == '0) ? S_FINISH : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else begin
`ifdef DDS_SWEEP_PHADJ_EN
                    state_nxt = S_PHWAIT;
`else
                    state_nxt = cnt_zero ? adv_state : S_DWELL;
`endif
                end
            end
            S_DWELL: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt = cnt_zero ? adv_state : S_DWELL;
                end
            end
`ifdef DDS_SWEEP_PHADJ_EN
            // The ready cycle is the first counted dwell cycle
            S_PHWAIT: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (ph_ok) begin
                    state_nxt = cnt_zero ? adv_state : S_DWELL;
                end
            end
`endif
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Registered-output next values, derived from the state being entered
    always_comb begin
        freq_nxt     = freq;
        step_idx_nxt = step_idx;
        if (state_nxt == S_ISSUE) begin
            if (state == S_IDLE) begin
                freq_nxt     = f_start;
                step_idx_nxt = '0;
            end else begin
                freq_nxt     = freq + step_r;
                step_idx_nxt = idx_plus1[IDX_W-1:0];
            end
        end
        synch_nxt = (state_nxt == S_ISSUE);
        done_nxt  = (state_nxt == S_FINISH);
`ifdef DDS_SWEEP_PHADJ_EN
        busy_nxt  = (state_nxt == S_ISSUE) || (state_nxt == S_DWELL) || (state_nxt == S_PHWAIT);
        ph_adj_start_nxt = (state == S_ISSUE) && (state_nxt == S_PHWAIT);
`else
        busy_nxt  = (state_nxt == S_ISSUE) || (state_nxt == S_DWELL);
`endif
    end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl (default build): sweep points and done pulses are
// predicted from the sweep parameters into queues and matched as the DUT emits them.
module tb_dds_sweep_ctrl;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic [31:0] f_start;
    logic [31:0] f_step;
    logic [15:0] n_steps;
    logic [31:0] dwell_time;
    logic        ph_adj_ready;
    logic [31:0] freq;
    logic        synch;
    logic        ph_adj_start;
    logic        busy;
    logic        done;
    logic [15:0] step_idx;

    dds_sweep_ctrl #(.IDX_W(16), .DWELL_W(32)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .abort        (abort),
        .f_start      (f_start),
        .f_step       (f_step),
        .n_steps      (n_steps),
        .dwell_time   (dwell_time),
        .ph_adj_ready (ph_adj_ready),
        .freq         (freq),
        .synch        (synch),
        .ph_adj_start (ph_adj_start),
        .busy         (busy),
        .done         (done),
        .step_idx     (step_idx)
    );

    typedef struct {
        int          cyc;
        logic [31:0] f;
        logic [15:0] idx;
    } syn_t;

    syn_t syn_q[$];
    int   done_q[$];

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   t0    = 0;
    int   bfrom = 1;
    int   bto   = 0;
    bit   chk_busy = 0;
    bit   mon_en   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Output monitor: sampled mid-cycle, away from the active edge
    always @(negedge clk) begin
        if (mon_en) begin
            int   rel;
            syn_t e;
            int   dc;
            rel = cyc - t0;
            check("synch_done_excl", 32'(synch & done), 32'd0);
            check("ph_adj_start_low", 32'(ph_adj_start), 32'd0);
            if (chk_busy) check("busy", 32'(busy), 32'(rel >= bfrom && rel <= bto));
            if (synch) begin
                check("synch_expected", 32'(syn_q.size() != 0), 32'd1);
                if (syn_q.size() != 0) begin
                    e = syn_q.pop_front();
                    check("synch_cycle", 32'(rel), 32'(e.cyc));
                    check("synch_freq", freq, e.f);
                    check("synch_idx", 32'(step_idx), 32'(e.idx));
                end
            end
            if (done) begin
                check("done_expected", 32'(done_q.size() != 0), 32'd1);
                if (done_q.size() != 0) begin
                    dc = done_q.pop_front();
                    check("done_cycle", 32'(rel), 32'(dc));
                end
            end
        end
    end

    // Predict one sweep, launch it; 'cut' is the first cycle at which the sweep is killed
    task automatic sweep(input logic [31:0] fs, input logic [31:0] fst, input logic [15:0] n,
                         input logic [31:0] dw, input int cut, input bit hold);
        int   d;
        int   done_at;
        syn_t e;
        d       = (dw == 0) ? 1 : int'(dw);
        done_at = (n == 0) ? 1 : 1 + int'(n) * d;
        @(posedge clk); #1;
        t0 = cyc;
        for (int i = 0; i < int'(n); i++) begin
            if (1 + i * d < cut) begin
                e.cyc = 1 + i * d;
                e.f   = fs + fst * 32'(i);
                e.idx = 16'(i);
                syn_q.push_back(e);
            end
        end
        if (done_at < cut) done_q.push_back(done_at);
        bfrom      = 1;
        bto        = (n == 0) ? 0 : ((done_at - 1 < cut - 1) ? done_at - 1 : cut - 1);
        chk_busy   = 1;
        f_start    = fs;
        f_step     = fst;
        n_steps    = n;
        dwell_time = dw;
        start      = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        // Parameters are latched; disturbing the inputs must not matter
        f_start    = $urandom;
        f_step     = $urandom;
        n_steps    = 16'($urandom_range(1, 50));
        dwell_time = $urandom_range(0, 9);
        if (hold) begin
            repeat (done_at - 1) @(posedge clk);
            #1 start = 1'b0;
        end
    endtask

    task automatic goto_cycle(input int c);
        while (cyc - t0 < c) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_idle(input int limit);
        for (int i = 0; i < limit; i++) begin
            @(posedge clk); #1;
            if (syn_q.size() == 0 && done_q.size() == 0 && !busy) break;
        end
        repeat (4) @(posedge clk);
        #1;
        check("synch_q_drained", 32'(syn_q.size()), 32'd0);
        check("done_q_drained", 32'(done_q.size()), 32'd0);
        syn_q.delete();
        done_q.delete();
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_freq"}, freq, 32'd0);
        check({tag, "_synch"}, 32'(synch), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_step_idx"}, 32'(step_idx), 32'd0);
        check({tag, "_ph_adj_start"}, 32'(ph_adj_start), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] prev;
        reset_n      = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        f_start      = 32'd0;
        f_step       = 32'd0;
        n_steps      = 16'd0;
        dwell_time   = 32'd0;
        ph_adj_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1 check_zero_outputs("reset");
        reset_n = 1'b1;
        @(posedge clk); #1;
        check_zero_outputs("post_reset");
        mon_en = 1;

        // Basic sweep
        sweep(32'h0147AE14, 32'h0147AE14, 16'd3, 32'd4, 1000, 0);
        wait_idle(100);
        check("basic_freq_hold", freq, 32'h03D70A3C);
        check("basic_idx_hold", 32'(step_idx), 32'd2);

        // Wrap through 2^32 with a positive step
        sweep(32'hFFFFFFF0, 32'h00000020, 16'd2, 32'd1, 1000, 0);
        wait_idle(100);
        check("wrap_freq_hold", freq, 32'h00000010);

        // Negative step
        sweep(32'hFFFFFFF0, 32'hFFFFFFFF, 16'd2, 32'd1, 1000, 0);
        wait_idle(100);
        check("neg_freq_hold", freq, 32'hFFFFFFEF);

        // Abort at cycle 6
        sweep(32'h0147AE14, 32'h0147AE14, 16'd3, 32'd4, 7, 0);
        goto_cycle(6);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        wait_idle(100);
        check("abort_freq_hold", freq, 32'h028F5C28);
        check("abort_idx_hold", 32'(step_idx), 32'd1);

        // n_steps = 0: done at cycle 1, no synch, freq untouched
        prev = freq;
        sweep(32'h12345678, 32'h00000001, 16'd0, 32'd4, 1000, 0);
        wait_idle(100);
        check("nsteps0_freq_hold", freq, prev);

        // dwell_time = 0 behaves as 1
        sweep(32'h00001000, 32'h00000100, 16'd3, 32'd0, 1000, 0);
        wait_idle(100);
        check("dwell0_freq_hold", freq, 32'h00001200);

        // start held high for the whole sweep: no restart
        sweep(32'h0147AE14, 32'h0147AE14, 16'd3, 32'd4, 1000, 1);
        wait_idle(100);
        check("hold_start_busy", 32'(busy), 32'd0);

        // start together with abort in IDLE: nothing happens
        prev = freq;
        @(posedge clk); #1;
        t0       = cyc;
        bfrom    = 1;
        bto      = 0;
        chk_busy = 1;
        f_start  = 32'hDEADBEEF;
        n_steps  = 16'd2;
        dwell_time = 32'd2;
        start    = 1'b1;
        abort    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        abort    = 1'b0;
        wait_idle(20);
        check("start_abort_freq", freq, prev);

        // Asynchronous reset mid-cycle 7, then a fresh sweep
        sweep(32'h0147AE14, 32'h0147AE14, 16'd3, 32'd4, 7, 0);
        goto_cycle(7);
        #2 reset_n = 1'b0;
        #1 check_zero_outputs("async_reset");
        @(posedge clk);
        #2 reset_n = 1'b1;
        wait_idle(20);
        sweep(32'h0147AE14, 32'h0147AE14, 16'd3, 32'd4, 1000, 0);
        wait_idle(100);
        check("after_reset_freq", freq, 32'h03D70A3C);

        chk_busy = 0;
        mon_en   = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
